// File: rtl/powlib_bus_pkg.sv
// rtl/powlib_bus_pkg.sv - shared FSM type and default widths for the bus burst block
//
// Purpose : common definitions imported by powlib_busburst and its helpers.
// Contents: bb_state_t (IDLE, BURST), default bus address/data/length widths.
package powlib_bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } bb_state_t;

  localparam int BUS_AW_DEF = 2;
  localparam int BUS_DW_DEF = 4;
  localparam int BUS_LW_DEF = 4;

endpackage

// File: rtl/powlib_busburst_ctr.sv
// rtl/powlib_busburst_ctr.sv - loadable down-counter with zero flag
//
// Purpose : holds the remaining-beat count of a burst.
// Ports   : clk, rst        - clock, asynchronous active-low reset
//           i_load          - load i_load_val (has priority over i_dec)
//           i_load_val[W]   - value to load
//           i_dec           - decrement by one; holds at zero
//           o_zero          - counter currently equals zero
module powlib_busburst_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/powlib_busburst.sv
// rtl/powlib_busburst.sv - turns a (address, length) command plus payload stream into addressed bus write beats
//
// Purpose : accepts a burst command, then tags each payload beat with an
//           incrementing (wrapping) address into a single-stage output register.
// Ports   : clk, rst                 - clock, asynchronous active-low reset
//           cmdaddr/cmdlen/cmdvld/cmdrdy - burst command (cmdlen = beats - 1)
//           indata/invld/inrdy       - payload stream
//           wrdata/wraddr/wrvld/wrrdy - addressed bus write beat
//           wrnf                     - downstream nearly-full, stalls payload intake
//           busy                     - burst in progress
//           done                     - one-cycle pulse after the last beat's bus handshake
//           beatcnt[32]              - saturating bus-handshake count (POWLIB_BUSBURST_STAT_EN only)
// Macro   : POWLIB_BUSBURST_STAT_EN adds the beatcnt port and counter.
module powlib_busburst
  import powlib_bus_pkg::*;
#(
  parameter int B_AW = BUS_AW_DEF,
  parameter int B_DW = BUS_DW_DEF,
  parameter int LW   = BUS_LW_DEF,
  parameter     ID   = "BUSBURST",
  parameter int EDBG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] cmdaddr,
  input  logic [LW-1:0]   cmdlen,
  input  logic            cmdvld,
  output logic            cmdrdy,
  input  logic [B_DW-1:0] indata,
  input  logic            invld,
  output logic            inrdy,
  output logic [B_DW-1:0] wrdata,
  output logic [B_AW-1:0] wraddr,
  output logic            wrvld,
  input  logic            wrrdy,
  input  logic            wrnf,
  output logic            busy,
  output logic            done
`ifdef POWLIB_BUSBURST_STAT_EN
  ,
  output logic [31:0]     beatcnt
`endif
);

  bb_state_t       r_state;
  bb_state_t       w_state_nxt;
  logic [B_AW-1:0] r_addr;
  logic [B_DW-1:0] r_wrdata;
  logic [B_AW-1:0] r_wraddr;
  logic            r_wrvld;
  logic            r_pend_last;
  logic            r_done;

  logic            w_cmd_acc;
  logic            w_slot_free;
  logic            w_load;
  logic            w_ctr_zero;
  logic            w_last;
  logic            w_bus_hs;

  // Handshake decode. The command port is open in IDLE even while the previous
  // burst's last beat still sits in the output register, so bursts run back-to-back.
  assign cmdrdy      = (r_state == IDLE);
  assign busy        = (r_state == BURST);
  assign w_slot_free = !r_wrvld || wrrdy;
  assign inrdy       = (r_state == BURST) && w_slot_free && !wrnf;
  assign w_cmd_acc   = cmdvld && cmdrdy;
  assign w_load      = invld && inrdy;
  assign w_last      = w_load && w_ctr_zero;
  assign w_bus_hs    = r_wrvld && wrrdy;

  powlib_busburst_ctr #(
    .W (LW)
  ) u_beat_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cmd_acc),
    .i_load_val (cmdlen),
    .i_dec      (w_load),
    .o_zero     (w_ctr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_acc) w_state_nxt = BURST;
      BURST:   if (w_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address counter wraps silently at 2^B_AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else if (w_cmd_acc) begin
      r_addr <= cmdaddr;
    end else if (w_load) begin
      r_addr <= r_addr + B_AW'(1);
    end
  end

  // Output register. r_pend_last travels with the beat so done fires only when
  // the burst's final beat actually leaves, not when it is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrvld     <= 1'b0;
      r_wrdata    <= '0;
      r_wraddr    <= '0;
      r_pend_last <= 1'b0;
    end else if (w_load) begin
      r_wrvld     <= 1'b1;
      r_wrdata    <= indata;
      r_wraddr    <= r_addr;
      r_pend_last <= w_ctr_zero;
    end else if (w_bus_hs) begin
      r_wrvld     <= 1'b0;
      r_pend_last <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_bus_hs && r_pend_last;
    end
  end

  assign wrdata = r_wrdata;
  assign wraddr = r_wraddr;
  assign wrvld  = r_wrvld;
  assign done   = r_done;

`ifdef POWLIB_BUSBURST_STAT_EN
  logic [31:0] r_beatcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beatcnt <= '0;
    end else if (w_bus_hs && (r_beatcnt != 32'hFFFF_FFFF)) begin
      r_beatcnt <= r_beatcnt + 32'd1;
    end
  end

  assign beatcnt = r_beatcnt;
`endif

  // Debug builds keep the instance tag as a named constant net for netlist/wave lookup.
  if (EDBG != 0) begin : g_dbg
    logic [$bits(ID)-1:0] w_dbg_id;
    assign w_dbg_id = ID;
  end

endmodule

// File: tb/tb_powlib_busburst.sv
// tb/tb_powlib_busburst.sv - self-checking bench for powlib_busburst
module tb_powlib_busburst;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cmdaddr;
  logic [3:0] cmdlen;
  logic       cmdvld;
  logic       cmdrdy;
  logic [7:0] indata;
  logic       invld;
  logic       inrdy;
  logic [7:0] wrdata;
  logic [3:0] wraddr;
  logic       wrvld;
  logic       wrrdy;
  logic       wrnf;
  logic       busy;
  logic       done;
`ifdef POWLIB_BUSBURST_STAT_EN
  logic [31:0] beatcnt;
`endif

  powlib_busburst #(
    .B_AW (4),
    .B_DW (8),
    .LW   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cmdaddr (cmdaddr),
    .cmdlen  (cmdlen),
    .cmdvld  (cmdvld),
    .cmdrdy  (cmdrdy),
    .indata  (indata),
    .invld   (invld),
    .inrdy   (inrdy),
    .wrdata  (wrdata),
    .wraddr  (wraddr),
    .wrvld   (wrvld),
    .wrrdy   (wrrdy),
    .wrnf    (wrnf),
    .busy    (busy),
    .done    (done)
`ifdef POWLIB_BUSBURST_STAT_EN
    ,
    .beatcnt (beatcnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected {addr,data} beats in order and expected done count.
  logic [11:0] exp_q[$];
  int          exp_done = 0;

  // Observation side (collected only, checked in the main sequence).
  logic [11:0] obs_q[$];
  int          hs_cyc[$];
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          hold_err = 0;
  int          acc_cyc  = 0;
  logic        p_hold   = 1'b0;
  logic [3:0]  p_addr   = '0;
  logic [7:0]  p_data   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (wrvld && wrrdy) begin
        obs_q.push_back({wraddr, wrdata});
        hs_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (p_hold && (!wrvld || wraddr != p_addr || wrdata != p_data)) hold_err = hold_err + 1;
      if (wrvld && !wrrdy && inrdy) hold_err = hold_err + 1;
      p_hold = wrvld && !wrrdy;
      p_addr = wraddr;
      p_data = wrdata;
    end else begin
      p_hold = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    cmdvld = 1'b0;
    invld  = 1'b0;
    wrnf   = 1'b0;
    wrrdy  = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_burst(input logic [3:0] a, input logic [3:0] l, input int rdy_pct,
                          input int nf_pct, input int vld_pct, input bit fixed);
    logic [7:0] d[$];
    int  sent;
    int  n;
    bit  acc;
    n    = int'(l) + 1;
    sent = 0;
    acc  = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      logic [3:0] ea;
      v  = fixed ? 8'((i + 1) * 17) : 8'($urandom);
      ea = 4'((int'(a) + i) % 16);
      d.push_back(v);
      exp_q.push_back({ea, v});
    end
    exp_done = exp_done + 1;
    cmdaddr = a;
    cmdlen  = l;
    cmdvld  = 1'b1;
    for (int c = 0; c < 400 && !(acc && sent == n); c++) begin
      invld  = acc && (sent < n) && ($urandom_range(99) < vld_pct);
      indata = (acc && sent < n) ? d[sent] : 8'h00;
      wrrdy  = $urandom_range(99) < rdy_pct;
      wrnf   = $urandom_range(99) < nf_pct;
      @(negedge clk);
      if (cmdvld && cmdrdy) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end
      if (invld && inrdy) sent = sent + 1;
      @(posedge clk);
      #1;
      if (acc) cmdvld = 1'b0;
    end
    chk("burst_complete", 32'(acc && sent == n), 32'd1);
    invld = 1'b0;
  endtask

  initial begin
    int base;
    int dsave;
    int obs_at_rst;
    logic [7:0] nd[4];

    rst = 1'b0; cmdaddr = '0; cmdlen = '0; cmdvld = 1'b0;
    indata = '0; invld = 1'b0; wrrdy = 1'b0; wrnf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdrdy", 32'(cmdrdy), 32'd1);
    chk("rst_inrdy",  32'(inrdy),  32'd0);
    chk("rst_wrvld",  32'(wrvld),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_wrdata", 32'(wrdata), 32'd0);
    chk("rst_wraddr", 32'(wraddr), 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_cmdrdy", 32'(cmdrdy), 32'd1);

    // Directed burst: addr 3, 4 beats 11,22,33,44 at full rate.
    base = obs_q.size();
    do_burst(4'h3, 4'd3, 100, 0, 100, 1'b1);
    drain(4);
    chk("d1_beats", 32'(obs_q.size() - base), 32'd4);
    if (obs_q.size() >= base + 4) begin
      chk("d1_latency", 32'(hs_cyc[base] - acc_cyc), 32'd2);
      for (int i = 1; i < 4; i++) chk("d1_throughput", 32'(hs_cyc[base+i] - hs_cyc[base+i-1]), 32'd1);
      chk("d1_done_cycle", 32'(done_cyc), 32'(hs_cyc[base+3] + 1));
    end
    chk("d1_done_count", 32'(done_cnt), 32'd1);

    // Address wrap.
    do_burst(4'hE, 4'd3, 100, 0, 100, 1'b0);
    drain(4);

    // Reset during beat 2 of 4: first beat already delivered, second discarded.
    cmdaddr = 4'h5; cmdlen = 4'd3; cmdvld = 1'b1; wrrdy = 1'b1; wrnf = 1'b0; invld = 1'b0;
    step();
    cmdvld = 1'b0; invld = 1'b1; indata = 8'hA0;
    exp_q.push_back({4'h5, 8'hA0});
    step();
    indata = 8'hA1;
    step();
    wrrdy = 1'b0; invld = 1'b0;
    dsave = done_cnt;
    #2 rst = 1'b0;
    #1;
    obs_at_rst = obs_q.size();
    chk("midrst_wrvld",  32'(wrvld),  32'd0);
    chk("midrst_busy",   32'(busy),   32'd0);
    chk("midrst_cmdrdy", 32'(cmdrdy), 32'd1);
    chk("midrst_inrdy",  32'(inrdy),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    chk("midrst_cmdrdy_after", 32'(cmdrdy), 32'd1);
    chk("midrst_no_done", 32'(done_cnt), 32'(dsave));

    // Nearly-full: intake stops, held beat still drains, intake resumes when wrnf drops.
    for (int i = 0; i < 4; i++) nd[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) exp_q.push_back({4'(9 + i), nd[i]});
    exp_done = exp_done + 1;
    cmdaddr = 4'h9; cmdlen = 4'd3; cmdvld = 1'b1; wrrdy = 1'b0; wrnf = 1'b0;
    step();
    cmdvld = 1'b0; invld = 1'b1; indata = nd[0];
    step();
    wrnf = 1'b1; indata = nd[1];
    #1 chk("nf_inrdy_held", 32'(inrdy), 32'd0);
    step();
    chk("nf_beat_held", 32'(wrvld), 32'd1);
    wrrdy = 1'b1;
    #1 chk("nf_inrdy_drain", 32'(inrdy), 32'd0);
    step();
    chk("nf_drained", 32'(wrvld), 32'd0);
    wrnf = 1'b0;
    #1 chk("nf_resume_inrdy", 32'(inrdy), 32'd1);
    step();
    chk("nf_resume_addr", 32'(wraddr), 32'hA);
    indata = nd[2];
    step();
    indata = nd[3];
    step();
    drain(4);

    // Length boundaries, then randomized back-to-back bursts with stalls.
    do_burst(4'h0, 4'd0, 100, 0, 100, 1'b0);
    do_burst(4'h7, 4'd15, 70, 20, 80, 1'b0);
    for (int k = 0; k < 10; k++) begin
      do_burst(4'($urandom), 4'($urandom_range(0, 15)),
               int'($urandom_range(30, 100)), int'($urandom_range(0, 40)),
               int'($urandom_range(40, 100)), 1'b0);
    end
    drain(8);

    chk("beat_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("beat%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
    chk("done_total", 32'(done_cnt), 32'(exp_done));
    chk("hold_stable", 32'(hold_err), 32'd0);
`ifdef POWLIB_BUSBURST_STAT_EN
    chk("beatcnt", beatcnt, 32'(obs_q.size() - obs_at_rst));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
